// File: rtl/pong_pkg.sv
// Shared types and constants for the ping-pong rally controller.
// Pure declarations: no logic, no latency, no backpressure.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_SERVE,
        ST_MOVE_R,
        ST_MOVE_L,
        ST_POINT,
        ST_OVER
    } state_t;

    localparam int         LED_N     = 6;
    localparam logic [2:0] POS_P1    = 3'd0;
    localparam logic [2:0] POS_P2    = 3'd5;
    localparam logic       PLAYER_P1 = 1'b0;
    localparam logic       PLAYER_P2 = 1'b1;

    function automatic logic [LED_N-1:0] pos_to_led(input logic [2:0] pos);
        logic [LED_N-1:0] one;
        one = {{(LED_N-1){1'b0}}, 1'b1};
        return one << pos;
    endfunction

endpackage

// File: rtl/pong_edge_detect.sv
// Turns a debounced button level into a single-cycle press pulse, same cycle as the rising level.
// No backpressure; the press is suppressed while reset is asserted.
module pong_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_lvl,
    output logic o_press
);

    logic r_prev;

    // Reset also loads the live level, so a button held through reset never counts as a press.
    always_ff @(posedge clk) begin
        r_prev <= i_lvl;
    end

    assign o_press = reset & i_lvl & ~r_prev;

endmodule

// File: rtl/pong_rally_ctrl.sv
// Rally sequencer: serve, ball motion on tick, hit/miss judgement, scoring; all outputs registered.
// One-cycle latency from sampled input to outputs; no backpressure, events are acted on when sampled.
module pong_rally_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int PAUSE_TICKS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             P1,
    input  logic             P2,
    output logic [LED_N-1:0] led,
    output logic [3:0]       score1,
    output logic [3:0]       score2,
    output logic             serving,
    output logic             server,
    output logic             game_over,
    output logic             winner
);

    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [3:0] PAUSE_LAST = 4'(PAUSE_TICKS - 1);

    logic w_p1_press;
    logic w_p2_press;
    logic w_award;
    logic w_award_to;
    logic [3:0] w_scorer_pts;

    state_t           r_state;
    logic [2:0]       r_pos;
    logic [3:0]       r_pause;
    logic [3:0]       r_score1;
    logic [3:0]       r_score2;
    logic             r_scorer;
    logic             r_server;
    logic             r_serving;
    logic             r_game_over;
    logic             r_winner;
    logic [LED_N-1:0] r_led;

    pong_edge_detect u_edge_p1 (
        .clk     (clk),
        .reset   (reset),
        .i_lvl   (P1),
        .o_press (w_p1_press)
    );

    pong_edge_detect u_edge_p2 (
        .clk     (clk),
        .reset   (reset),
        .i_lvl   (P2),
        .o_press (w_p2_press)
    );

    // A point is lost by swinging early or by letting a tick pass at the end; a hit beats a tick.
    always_comb begin
        w_award    = 1'b0;
        w_award_to = PLAYER_P1;
        case (r_state)
            ST_MOVE_R: begin
                if ((w_p2_press && r_pos != POS_P2) ||
                    (!w_p2_press && tick && r_pos == POS_P2)) begin
                    w_award    = 1'b1;
                    w_award_to = PLAYER_P1;
                end
            end
            ST_MOVE_L: begin
                if ((w_p1_press && r_pos != POS_P1) ||
                    (!w_p1_press && tick && r_pos == POS_P1)) begin
                    w_award    = 1'b1;
                    w_award_to = PLAYER_P2;
                end
            end
            default: begin
                w_award    = 1'b0;
                w_award_to = PLAYER_P1;
            end
        endcase
    end

    assign w_scorer_pts = (r_scorer == PLAYER_P2) ? r_score2 : r_score1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_SERVE;
            r_pos       <= POS_P1;
            r_pause     <= 4'd0;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_scorer    <= PLAYER_P1;
            r_server    <= PLAYER_P1;
            r_serving   <= 1'b1;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_led       <= pos_to_led(POS_P1);
        end else if (w_award) begin
            r_state  <= ST_POINT;
            r_pause  <= 4'd0;
            r_scorer <= w_award_to;
            r_led    <= '1;
            if (w_award_to == PLAYER_P2) begin
                r_score2 <= r_score2 + 4'd1;
            end else begin
                r_score1 <= r_score1 + 4'd1;
            end
        end else begin
            case (r_state)
                ST_SERVE: begin
                    if (r_server == PLAYER_P1 && w_p1_press) begin
                        r_state   <= ST_MOVE_R;
                        r_serving <= 1'b0;
                    end else if (r_server == PLAYER_P2 && w_p2_press) begin
                        r_state   <= ST_MOVE_L;
                        r_serving <= 1'b0;
                    end
                end
                ST_MOVE_R: begin
                    if (w_p2_press) begin
                        r_state <= ST_MOVE_L;
                    end else if (tick) begin
                        r_pos <= r_pos + 3'd1;
                        r_led <= pos_to_led(r_pos + 3'd1);
                    end
                end
                ST_MOVE_L: begin
                    if (w_p1_press) begin
                        r_state <= ST_MOVE_R;
                    end else if (tick) begin
                        r_pos <= r_pos - 3'd1;
                        r_led <= pos_to_led(r_pos - 3'd1);
                    end
                end
                ST_POINT: begin
                    if (tick) begin
                        if (r_pause != PAUSE_LAST) begin
                            r_pause <= r_pause + 4'd1;
                        end else if (w_scorer_pts == WIN_VAL) begin
                            r_state     <= ST_OVER;
                            r_led       <= '0;
                            r_game_over <= 1'b1;
                            r_winner    <= r_scorer;
                        end else begin
                            // The player who conceded serves from their own end.
                            r_state   <= ST_SERVE;
                            r_serving <= 1'b1;
                            r_server  <= ~r_scorer;
                            if (r_scorer == PLAYER_P1) begin
                                r_pos <= POS_P2;
                                r_led <= pos_to_led(POS_P2);
                            end else begin
                                r_pos <= POS_P1;
                                r_led <= pos_to_led(POS_P1);
                            end
                        end
                    end
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state <= ST_SERVE;
                end
            endcase
        end
    end

    assign led       = r_led;
    assign score1    = r_score1;
    assign score2    = r_score2;
    assign serving   = r_serving;
    assign server    = r_server;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_pong_rally_ctrl.sv
// Directed bench for pong_rally_ctrl with a reference model checked every cycle.
module tb_pong_rally_ctrl;

    localparam int WIN   = 2;
    localparam int PAUSE = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       tick  = 1'b0;
    logic       P1    = 1'b0;
    logic       P2    = 1'b0;
    logic [5:0] led;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       serving;
    logic       server;
    logic       game_over;
    logic       winner;

    always #5 clk = ~clk;

    pong_rally_ctrl #(.WIN_SCORE(WIN), .PAUSE_TICKS(PAUSE)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .P1        (P1),
        .P2        (P2),
        .led       (led),
        .score1    (score1),
        .score2    (score2),
        .serving   (serving),
        .server    (server),
        .game_over (game_over),
        .winner    (winner)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: phase 0=waiting serve, 1=ball in flight, 2=point flash, 3=game over.
    int m_phase, m_pos, m_dir, m_server, m_scorer, m_pause;
    int m_pts [2];
    bit m_prev1, m_prev2;

    function automatic void m_award(input int who);
        m_pts[who]++;
        m_scorer = who;
        m_pause  = 0;
        m_phase  = 2;
    endfunction

    always @(posedge clk) begin
        bit p1p, p2p, hit;
        int swinger, far_end;
        if (!reset) begin
            m_phase = 0; m_pos = 0; m_dir = 1; m_server = 0; m_scorer = 0;
            m_pause = 0; m_pts[0] = 0; m_pts[1] = 0;
        end else begin
            p1p = P1 && !m_prev1;
            p2p = P2 && !m_prev2;
            case (m_phase)
                0: begin
                    if (m_server == 0 && p1p) begin m_phase = 1; m_dir = 1; end
                    else if (m_server == 1 && p2p) begin m_phase = 1; m_dir = -1; end
                end
                1: begin
                    swinger = (m_dir > 0) ? 1 : 0;
                    far_end = (m_dir > 0) ? 5 : 0;
                    hit     = swinger ? p2p : p1p;
                    if (hit) begin
                        if (m_pos == far_end) m_dir = -m_dir;
                        else m_award(1 - swinger);
                    end else if (tick) begin
                        if (m_pos == far_end) m_award(1 - swinger);
                        else m_pos = m_pos + m_dir;
                    end
                end
                2: begin
                    if (tick) begin
                        m_pause++;
                        if (m_pause == PAUSE) begin
                            if (m_pts[m_scorer] == WIN) m_phase = 3;
                            else begin
                                m_phase  = 0;
                                m_server = 1 - m_scorer;
                                m_pos    = m_server ? 5 : 0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        m_prev1 = P1;
        m_prev2 = P2;
    end

    function automatic logic [7:0] m_led();
        if (m_phase == 2) return 8'd63;
        if (m_phase == 3) return 8'd0;
        return 8'(1 << m_pos);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_led", {2'b00, led}, m_led());
            check("model_score1", {4'h0, score1}, 8'(m_pts[0]));
            check("model_score2", {4'h0, score2}, 8'(m_pts[1]));
            check("model_serving", {7'd0, serving}, 8'(m_phase == 0));
            check("model_server", {7'd0, server}, 8'(m_server));
            check("model_game_over", {7'd0, game_over}, 8'(m_phase == 3));
            if (m_phase == 3) check("model_winner", {7'd0, winner}, 8'(m_scorer));
        end
    end

    task automatic step(input logic t, input logic a, input logic b);
        tick = t; P1 = a; P2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic p1_lvl);
        reset = 1'b0;
        repeat (n) step(1'b0, p1_lvl, 1'b0);
        reset = 1'b1;
    endtask

    task automatic serve_p1();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset then serve and walk the ball to P2's end.
        do_reset(2, 1'b0);
        chk_en = 1'b1;
        check("rst_led", {2'b00, led}, 8'd1);
        check("rst_serving", {7'd0, serving}, 8'd1);
        check("rst_scores", {score1, score2}, 8'd0);
        check("rst_server", {7'd0, server}, 8'd0);
        check("rst_game_over", {7'd0, game_over}, 8'd0);
        step(1'b0, 1'b1, 1'b0);
        check("serve_led_held", {2'b00, led}, 8'd1);
        check("serve_serving", {7'd0, serving}, 8'd0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("walk_right_led", {2'b00, led}, 8'(1 << i));
        end

        // Return by P2 and a miss at P1's end.
        step(1'b0, 1'b0, 1'b1);
        check("hit_p2_led", {2'b00, led}, 8'd32);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, 1'b0, 1'b0);
            check("walk_left_led", {2'b00, led}, 8'(1 << i));
        end
        step(1'b1, 1'b0, 1'b0);
        check("miss_p1_score2", {4'h0, score2}, 8'd1);
        check("miss_p1_led", {2'b00, led}, 8'd63);
        ticks(2);
        check("pause_hold_led", {2'b00, led}, 8'd63);
        ticks(1);
        check("after_pause_server", {7'd0, server}, 8'd0);
        check("after_pause_led", {2'b00, led}, 8'd1);

        // Miss at P2's end, pause counts ticks only.
        do_reset(1, 1'b0);
        serve_p1();
        ticks(5);
        step(1'b1, 1'b0, 1'b0);
        check("miss_p2_score1", {4'h0, score1}, 8'd1);
        check("miss_p2_led", {2'b00, led}, 8'd63);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("pause_no_tick_led", {2'b00, led}, 8'd63);
        ticks(3);
        check("p2_serve_serving", {7'd0, serving}, 8'd1);
        check("p2_serve_server", {7'd0, server}, 8'd1);
        check("p2_serve_led", {2'b00, led}, 8'd32);

        // Early swing by P2 at pos 3.
        do_reset(1, 1'b0);
        serve_p1();
        ticks(3);
        check("early_pos3_led", {2'b00, led}, 8'd8);
        step(1'b0, 1'b0, 1'b1);
        check("early_score1", {4'h0, score1}, 8'd1);
        check("early_led", {2'b00, led}, 8'd63);

        // Tick and hit in the same cycle at pos 5 count as a hit.
        do_reset(1, 1'b0);
        serve_p1();
        ticks(5);
        step(1'b1, 1'b0, 1'b1);
        check("tie_scores", {score1, score2}, 8'd0);
        check("tie_led", {2'b00, led}, 8'd32);
        step(1'b0, 1'b0, 1'b0);
        ticks(1);
        check("tie_return_led", {2'b00, led}, 8'd16);

        // Button held through reset never serves.
        do_reset(1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        check("held_rst_serving", {7'd0, serving}, 8'd1);
        check("held_rst_led", {2'b00, led}, 8'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("held_serve_serving", {7'd0, serving}, 8'd0);
        for (int i = 0; i < 10; i++) step(1'((i % 2) == 0), 1'b1, 1'b0);
        check("held_walk_led", {2'b00, led}, 8'd32);
        check("held_walk_scores", {score1, score2}, 8'd0);

        // Both buttons in the same cycle: serve by P1, then P2 early swing with P1 ignored.
        do_reset(1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("both_serve_serving", {7'd0, serving}, 8'd0);
        check("both_serve_scores", {score1, score2}, 8'd0);
        step(1'b0, 1'b0, 1'b0);
        ticks(1);
        check("both_pos1_led", {2'b00, led}, 8'd2);
        step(1'b0, 1'b1, 1'b1);
        check("both_early_scores", {score1, score2}, 8'h10);

        // P2 wins two points and the game ends.
        do_reset(1, 1'b0);
        serve_p1();
        ticks(5);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("g1_score2", {4'h0, score2}, 8'd1);
        ticks(3);
        check("g1_server", {7'd0, server}, 8'd0);
        serve_p1();
        ticks(5);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        ticks(5);
        ticks(1);
        check("g2_score2", {4'h0, score2}, 8'd2);
        check("g2_not_over_yet", {7'd0, game_over}, 8'd0);
        ticks(3);
        check("over_game_over", {7'd0, game_over}, 8'd1);
        check("over_winner", {7'd0, winner}, 8'd1);
        check("over_led", {2'b00, led}, 8'd0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("over_stuck_game_over", {7'd0, game_over}, 8'd1);
        check("over_stuck_scores", {score1, score2}, 8'h02);
        check("over_stuck_led", {2'b00, led}, 8'd0);
        do_reset(1, 1'b0);
        check("rerst_led", {2'b00, led}, 8'd1);
        check("rerst_scores", {score1, score2}, 8'd0);
        check("rerst_game_over", {7'd0, game_over}, 8'd0);
        check("rerst_winner", {7'd0, winner}, 8'd0);
        check("rerst_serving", {7'd0, serving}, 8'd1);
        step(1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
